redmule_z_priority_arbiter: RTL and testbench

Decides, cycle by cycle, whether Z writeback or X prefetch owns the shared memory port. It sits directly upstream of the memory scheduler and drives its `z_priority_i` input, which the scheduler forwards unchanged to the streamer. Arbitration uses Z output-buffer watermarks with hysteresis, a Z burst budget for fairness, an optional Z starvation timeout, and an end-of-job drain mode.

---
 rtl/redmule_z_priority_arbiter.sv | 145 ++++++++++++++
 tb/tb_redmule_z_priority_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/redmule_z_priority_arbiter.sv
// Z-writeback vs X-prefetch arbiter for the shared memory port.
// Z takes the port on a high fill watermark and releases it at the low
// watermark (hysteresis). It also releases after a bounded handshake burst
// while X waits, or when X is starving. A flush drains Z completely.
// Optional feature macro: REDMULE_ZPRIO_STARVE_EN adds a Z starvation timeout.
module redmule_z_priority_arbiter #(
  parameter int unsigned ZD       = 16,
  parameter int unsigned HIGH_WM  = 12,
  parameter int unsigned LOW_WM   = 4,
  parameter int unsigned Z_BURST  = 8,
  parameter int unsigned MAX_WAIT = 64,
  localparam int unsigned ZFW     = $clog2(ZD + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           enable_i,
  input  logic           flush_i,
  input  logic [ZFW-1:0] z_fill_i,
  input  logic           z_pending_i,
  input  logic           z_hs_i,
  input  logic           x_pending_i,
  input  logic           x_buf_empty_i,
  output logic           z_priority_o,
  output logic           drain_done_o,
  output logic [1:0]     state_o
);

  localparam int unsigned BW = $clog2(Z_BURST) + 1;
  localparam logic [ZFW-1:0] HighWm   = ZFW'(HIGH_WM);
  localparam logic [ZFW-1:0] LowWm    = ZFW'(LOW_WM);
  localparam logic [BW-1:0]  BurstMax = BW'(Z_BURST - 1);

  typedef enum logic [1:0] {
    StXPrio  = 2'd0,
    StZPrio  = 2'd1,
    StZDrain = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic           drain_done_q, drain_done_d;
  logic           starve_hit;

`ifdef REDMULE_ZPRIO_STARVE_EN
  localparam int unsigned SW = $clog2(MAX_WAIT) + 1;
  localparam logic [SW-1:0] StarveMax = SW'(MAX_WAIT - 1);

  logic [SW-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == StarveMax) && z_pending_i;

  // Starvation counter: counts consecutive stalled Z cycles while X owns the port.
  always_comb begin
    starve_d = starve_q;
    if (enable_i) begin
      if (state_q != StXPrio || state_d != StXPrio || z_hs_i || !z_pending_i) begin
        starve_d = '0;
      end else if (starve_q != StarveMax) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
  assign starve_hit      = 1'b0;
`endif

  // Next-state, burst counter and drain-done pulse; everything holds when disabled.
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    drain_done_d = 1'b0;
    if (enable_i) begin
      unique case (state_q)
        StXPrio: begin
          if (flush_i) begin
            state_d = StZDrain;
          end else if (z_fill_i >= HighWm) begin
            state_d = StZPrio;
          end else if (starve_hit) begin
            state_d = StZPrio;
          end
        end
        StZPrio: begin
          if (flush_i) begin
            state_d = StZDrain;
          end else if (z_fill_i <= LowWm) begin
            state_d = StXPrio;
          end else if (burst_q == BurstMax && z_hs_i && x_pending_i) begin
            state_d = StXPrio;
          end else if (x_buf_empty_i && x_pending_i && z_fill_i < HighWm) begin
            state_d = StXPrio;
          end
        end
        StZDrain: begin
          if (z_fill_i == '0 && !z_pending_i) begin
            state_d      = StXPrio;
            drain_done_d = 1'b1;
          end
        end
        default: state_d = StXPrio;
      endcase

      // Each Z tenure starts with a fresh burst budget.
      if (state_q != StZPrio && state_d == StZPrio) begin
        burst_d = '0;
      end else if (state_q == StZPrio && z_hs_i && burst_q != BurstMax) begin
        burst_d = burst_q + BW'(1);
      end
    end
  end

  // State and output registers; soft clear behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q      <= StXPrio;
      burst_q      <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign z_priority_o = (state_q != StXPrio);
  assign drain_done_o = drain_done_q;
  assign state_o      = state_q;

  // Fill level above buffer depth is illegal.
  a_fill_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(z_fill_i) <= int'(ZD));

endmodule

// File: tb/tb_redmule_z_priority_arbiter.sv
// Self-checking bench for redmule_z_priority_arbiter: directed scenarios plus
// randomized traffic, every cycle compared against a rule-level reference model.
module tb_redmule_z_priority_arbiter;

  localparam int ZD = 16, HI = 12, LO = 4, ZB = 8, MW = 64;

  logic       clk = 1'b0;
  logic       rst, clear, en, flush, zp, hs, xp, xe;
  logic [4:0] fill;
  logic       prio, done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0=X owns, 1=Z owns, 2=draining.
  int m_mode = 0;
  int m_hs_tenure = 0;  // handshakes seen in the current Z tenure (unbounded)
  int m_wait = 0;       // consecutive stalled-Z cycles while X owns
  int m_done = 0;

  always #5 clk = ~clk;

  redmule_z_priority_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .enable_i     (en),
    .flush_i      (flush),
    .z_fill_i     (fill),
    .z_pending_i  (zp),
    .z_hs_i       (hs),
    .x_pending_i  (xp),
    .x_buf_empty_i(xe),
    .z_priority_o (prio),
    .drain_done_o (done),
    .state_o      (state)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit starve_en();
`ifdef REDMULE_ZPRIO_STARVE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Apply the arbitration rules to the inputs sampled at this edge.
  task automatic model_step();
    int nxt;
    int f = int'(fill);
    if (rst || clear) begin
      m_mode = 0; m_hs_tenure = 0; m_wait = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!en) return;
    nxt = m_mode;
    if (m_mode == 2) begin
      if (f == 0 && !zp) begin
        nxt = 0;
        m_done = 1;
      end
    end else if (flush) begin
      nxt = 2;
    end else if (m_mode == 0) begin
      if (f >= HI) nxt = 1;
      else if (starve_en() && zp && m_wait >= MW - 1) nxt = 1;
    end else begin
      if (f <= LO) nxt = 0;
      else if (hs && xp && m_hs_tenure >= ZB - 1) nxt = 0;
      else if (xe && xp && f < HI) nxt = 0;
    end
    if (m_mode == 0 && nxt == 0 && zp && !hs) m_wait++;
    else m_wait = 0;
    if (m_mode == 1 && hs) m_hs_tenure++;
    if (nxt == 1 && m_mode != 1) m_hs_tenure = 0;
    m_mode = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("prio", int'(prio), (m_mode != 0) ? 1 : 0);
    check_eq("state", int'(state), m_mode);
    check_eq("drain_done", int'(done), m_done);
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; en = 1; flush = 0; fill = '0;
    zp = 0; hs = 0; xp = 0; xe = 0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  int fw;

  initial begin
    idle_inputs();

    // Reset holds X priority even with a high fill.
    rst = 1; fill = 5'd15;
    tick(); check_eq("rst_prio0", int'(prio), 0);
    tick(); check_eq("rst_state0", int'(state), 0);
    rst = 0;
    tick(); check_eq("post_rst_prio", int'(prio), 1);

    // Hysteresis.
    do_clear();
    for (int f = 0; f <= 12; f++) begin
      fill = 5'(f); tick();
      check_eq("ramp_up", int'(prio), (f == 12) ? 1 : 0);
    end
    for (int f = 11; f >= 4; f--) begin
      fill = 5'(f); tick();
      check_eq("ramp_down", int'(prio), (f == 4) ? 0 : 1);
    end

    // Burst fairness, X waiting.
    do_clear();
    fill = 5'd12; tick();
    fill = 5'd10; xp = 1; hs = 1;
    for (int i = 1; i <= 8; i++) begin
      tick(); check_eq("burst_xwait", int'(prio), (i == 8) ? 0 : 1);
    end
    // Burst with X idle keeps Z.
    hs = 0; xp = 0; fill = 5'd12; tick();
    fill = 5'd10; hs = 1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("burst_xidle", int'(prio), 1);
    hs = 0;

    // Starvation timeout.
    do_clear();
    fill = 5'd2; zp = 1;
    for (int i = 0; i < 63; i++) tick();
    check_eq("starve_63", int'(prio), 0);
    tick();
    check_eq("starve_64", int'(prio), starve_en() ? 1 : 0);
    for (int i = 0; i < 16; i++) tick();
    if (!starve_en()) check_eq("starve_off", int'(prio), 0);

    // Drain, with a second flush ignored.
    do_clear();
    fill = 5'd3; zp = 1; flush = 1; tick();
    check_eq("drain_enter", int'(state), 2);
    flush = 0; fill = 5'd2; tick();
    flush = 1; fill = 5'd1; tick();
    check_eq("drain_reflush", int'(state), 2);
    flush = 0; fill = 5'd0; tick();
    check_eq("drain_pending", int'(done), 0);
    zp = 0; tick();
    check_eq("drain_done", int'(done), 1);
    check_eq("drain_exit_state", int'(state), 0);
    tick();
    check_eq("drain_done_once", int'(done), 0);

    // Clear aborts a drain.
    fill = 5'd3; zp = 1; flush = 1; tick();
    flush = 0; fill = 5'd0; zp = 0; clear = 1; tick();
    check_eq("abort_state", int'(state), 0);
    check_eq("abort_no_done", int'(done), 0);
    clear = 0; tick();
    check_eq("abort_no_done2", int'(done), 0);

    // Randomized traffic.
    fw = 6;
    for (int i = 0; i < 4000; i++) begin
      fw = fw + int'($urandom_range(0, 4)) - 2;
      if (fw < 0) fw = 0;
      if (fw > ZD) fw = ZD;
      fill  = 5'(fw);
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      zp    = ($urandom_range(0, 9) < 7);
      hs    = ($urandom_range(0, 9) < 4);
      xp    = ($urandom_range(0, 9) < 6);
      xe    = ($urandom_range(0, 9) < 2);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
